lvl_state_scan: RTL

Parametrised level-state walker for the bin manager. It sits between the bin-manager control FSM and the level-states BRAM, whose entries are {dcd_bin, has_bkt}. In FIND mode it scans downward from a start level, reports the first level whose has_bkt is 0, and sets that flag. In CLEAR mode it clears has_bkt over a level range. Unlike the single-mode walker, it supports configurable BRAM read latency, a clear mode, not-found and error reporting, and a busy/done handshake.

---
 rtl/lvl_state_scan.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lvl_state_scan.sv
// lvl_state_scan: level-state walker for the bin manager.
// FIND scans the level-states BRAM downward from a start level for the
// first entry with has_bkt=0 and sets it. CLEAR clears has_bkt over the
// level range [lo_lvl_i, bkt_lvl_i]. BRAM entries are {dcd_bin, has_bkt}.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start_i, mode_i     request pulse (IDLE only), 0=FIND 1=CLEAR
//   bkt_lvl_i, lo_lvl_i start (highest) level, lowest level for CLEAR
//   busy_o, apply_o     high from accept edge until done_o
//   done_o              one-cycle completion pulse
//   found_o, err_o      FIND hit, request rejected
//   bkt_lvl_o/bkt_bin_o result level / bin
//   ram_*               level-states BRAM port (read latency RD_LAT)
module lvl_state_scan #(
  parameter int unsigned WIDTH_LVL              = 16,
  parameter int unsigned WIDTH_BIN_ID           = 10,
  parameter int unsigned ADDR_WIDTH_LVLS_STATES = 9,
  parameter int unsigned RD_LAT                 = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic                              mode_i,
  input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
  input  logic [WIDTH_LVL-1:0]              lo_lvl_i,
  output logic                              busy_o,
  output logic                              apply_o,
  output logic                              done_o,
  output logic                              found_o,
  output logic                              err_o,
  output logic [WIDTH_LVL-1:0]              bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]           bkt_bin_o,
  output logic                              ram_we_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_o,
  output logic [WIDTH_BIN_ID:0]             ram_data_o,
  input  logic [WIDTH_BIN_ID:0]             ram_data_i
);

  localparam int unsigned AW     = ADDR_WIDTH_LVLS_STATES;
  localparam int unsigned WAIT_W = 2;
  localparam logic [WIDTH_LVL-1:0] MAX_LVL = WIDTH_LVL'(2**AW - 1);
  // WAIT covers the read-latency cycles beyond the first one
  localparam logic [WAIT_W-1:0] WAIT_INIT = (RD_LAT > 2) ? WAIT_W'(RD_LAT - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CHK,
    S_WR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_LVL-1:0]  lvl_cnt_q, lvl_cnt_d;
  logic [WIDTH_LVL-1:0]  lo_lvl_q, lo_lvl_d;
  logic                  mode_q, mode_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic                    busy_d, apply_d, done_d, found_d, err_d, we_d;
  logic [WIDTH_LVL-1:0]    bkt_lvl_d;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_d;
  logic [AW-1:0]           addr_d;
  logic [WIDTH_BIN_ID:0]   wdata_d;

  logic [WIDTH_BIN_ID-1:0] dcd_bin;
  logic                    has_bkt;
  logic [WIDTH_LVL-1:0]    lvl_dec;

  assign dcd_bin = ram_data_i[WIDTH_BIN_ID:1];
  assign has_bkt = ram_data_i[0];
  assign lvl_dec = lvl_cnt_q - WIDTH_LVL'(1);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lvl_cnt_q  <= '0;
      lo_lvl_q   <= '0;
      mode_q     <= 1'b0;
      wait_q     <= '0;
      busy_o     <= 1'b0;
      apply_o    <= 1'b0;
      done_o     <= 1'b0;
      found_o    <= 1'b0;
      err_o      <= 1'b0;
      bkt_lvl_o  <= '0;
      bkt_bin_o  <= '0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      state_q    <= state_d;
      lvl_cnt_q  <= lvl_cnt_d;
      lo_lvl_q   <= lo_lvl_d;
      mode_q     <= mode_d;
      wait_q     <= wait_d;
      busy_o     <= busy_d;
      apply_o    <= apply_d;
      done_o     <= done_d;
      found_o    <= found_d;
      err_o      <= err_d;
      bkt_lvl_o  <= bkt_lvl_d;
      bkt_bin_o  <= bkt_bin_d;
      ram_we_o   <= we_d;
      ram_addr_o <= addr_d;
      ram_data_o <= wdata_d;
    end
  end

  // Next-state and next-output logic. The read address is loaded on the
  // edge entering RD so the BRAM sees it for the whole RD cycle.
  always_comb begin
    state_d   = state_q;
    lvl_cnt_d = lvl_cnt_q;
    lo_lvl_d  = lo_lvl_q;
    mode_d    = mode_q;
    wait_d    = wait_q;
    busy_d    = busy_o;
    apply_d   = apply_o;
    done_d    = 1'b0;
    found_d   = found_o;
    err_d     = err_o;
    bkt_lvl_d = bkt_lvl_o;
    bkt_bin_d = bkt_bin_o;
    we_d      = 1'b0;
    addr_d    = ram_addr_o;
    wdata_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          lo_lvl_d = lo_lvl_i;
          busy_d   = 1'b1;
          apply_d  = 1'b1;
          found_d  = 1'b0;
          err_d    = 1'b0;
          if ((bkt_lvl_i > MAX_LVL) || (mode_i && (lo_lvl_i > bkt_lvl_i))) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            lvl_cnt_d = bkt_lvl_i;
            addr_d    = AW'(bkt_lvl_i);
            state_d   = S_RD;
          end
        end
      end

      S_RD: begin
        if (RD_LAT > 1) begin
          wait_d  = WAIT_INIT;
          state_d = S_WAIT;
        end else begin
          state_d = S_CHK;
        end
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CHK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      S_CHK: begin
        if (mode_q) begin
          bkt_lvl_d = lo_lvl_q;
          bkt_bin_d = dcd_bin;
          we_d      = 1'b1;
          wdata_d   = {dcd_bin, 1'b0};
          state_d   = S_WR;
        end else if (!has_bkt) begin
          bkt_lvl_d = lvl_cnt_q;
          bkt_bin_d = dcd_bin;
          found_d   = 1'b1;
          we_d      = 1'b1;
          wdata_d   = {dcd_bin, 1'b1};
          state_d   = S_WR;
        end else if (lvl_cnt_q != '0) begin
          lvl_cnt_d = lvl_dec;
          addr_d    = AW'(lvl_dec);
          state_d   = S_RD;
        end else begin
          bkt_lvl_d = '0;
          bkt_bin_d = dcd_bin;
          found_d   = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_WR: begin
        if (mode_q && (lvl_cnt_q > lo_lvl_q)) begin
          lvl_cnt_d = lvl_dec;
          addr_d    = AW'(lvl_dec);
          state_d   = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        apply_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
